// File: rtl/data_memory_arbiter_if.sv
// Signal bundle shared by the data-memory arbiter, its two requesters and the RAM.
// The slave view belongs to the arbiter; the master view to requesters plus RAM.
interface data_memory_arbiter_if #(
    parameter int ADDRESS_WIDTH       = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int DEBUG_ADDRESS_WIDTH = 6
) ();
    logic                           cpu_req;
    logic                           cpu_we;
    logic [ADDRESS_WIDTH-1:0]       cpu_address;
    logic [DATA_WIDTH-1:0]          cpu_write_data;
    logic [DATA_WIDTH-1:0]          cpu_read_data;
    logic                           cpu_ack;

    logic                           dbg_req;
    logic                           dbg_we;
    logic [DEBUG_ADDRESS_WIDTH-1:0] dbg_address;
    logic [DATA_WIDTH-1:0]          dbg_write_data;
    logic [DATA_WIDTH-1:0]          dbg_read_data;
    logic                           dbg_ack;

    logic [ADDRESS_WIDTH-1:0]       mem_address;
    logic [DATA_WIDTH-1:0]          mem_write_data;
    logic                           mem_we;
    logic [DATA_WIDTH-1:0]          mem_read_data;

    logic                           busy;
    logic                           grant_debug;

    modport slave (
        input  cpu_req,
        input  cpu_we,
        input  cpu_address,
        input  cpu_write_data,
        output cpu_read_data,
        output cpu_ack,
        input  dbg_req,
        input  dbg_we,
        input  dbg_address,
        input  dbg_write_data,
        output dbg_read_data,
        output dbg_ack,
        output mem_address,
        output mem_write_data,
        output mem_we,
        input  mem_read_data,
        output busy,
        output grant_debug
    );

    modport master (
        output cpu_req,
        output cpu_we,
        output cpu_address,
        output cpu_write_data,
        input  cpu_read_data,
        input  cpu_ack,
        output dbg_req,
        output dbg_we,
        output dbg_address,
        output dbg_write_data,
        input  dbg_read_data,
        input  dbg_ack,
        input  mem_address,
        input  mem_write_data,
        input  mem_we,
        output mem_read_data,
        input  busy,
        input  grant_debug
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Serializes processor and debug accesses onto one data RAM port.
// Processor wins ties until the debug side has waited STARVATION_LIMIT grants.
module data_memory_arbiter #(
    parameter int ADDRESS_WIDTH       = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int DEBUG_ADDRESS_WIDTH = 6,
    parameter int READ_LATENCY        = 1,
    parameter int STARVATION_LIMIT    = 4
) (
    input logic                  clock,
    input logic                  reset,
    data_memory_arbiter_if.slave bus
);
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int SW = (STARVATION_LIMIT > 0) ? $clog2(STARVATION_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(READ_LATENCY - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVATION_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    state_t                   state;
    logic [CW-1:0]            lat_cnt;
    logic [SW-1:0]            starve_count;
    logic                     req_we;

    logic                     any_req;
    logic                     pick_dbg;
    logic                     we_sel;
    logic [ADDRESS_WIDTH-1:0] dbg_address_ext;
    logic [ADDRESS_WIDTH-1:0] address_sel;
    logic [DATA_WIDTH-1:0]    write_data_sel;

    assign any_req  = bus.cpu_req | bus.dbg_req;
    assign pick_dbg = bus.dbg_req & (~bus.cpu_req | (starve_count == STARVE_MAX));

    assign dbg_address_ext = {{(ADDRESS_WIDTH - DEBUG_ADDRESS_WIDTH){1'b0}}, bus.dbg_address};

    assign we_sel         = pick_dbg ? bus.dbg_we : bus.cpu_we;
    assign address_sel    = pick_dbg ? dbg_address_ext : bus.cpu_address;
    assign write_data_sel = pick_dbg ? bus.dbg_write_data : bus.cpu_write_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            lat_cnt            <= '0;
            starve_count       <= '0;
            req_we             <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            bus.mem_we         <= 1'b0;
            bus.cpu_read_data  <= '0;
            bus.cpu_ack        <= 1'b0;
            bus.dbg_read_data  <= '0;
            bus.dbg_ack        <= 1'b0;
            bus.busy           <= 1'b0;
            bus.grant_debug    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state              <= ACCESS;
                        lat_cnt            <= '0;
                        req_we             <= we_sel;
                        bus.mem_address    <= address_sel;
                        bus.mem_write_data <= write_data_sel;
                        bus.mem_we         <= we_sel;
                        bus.busy           <= 1'b1;
                        bus.grant_debug    <= pick_dbg;
                    end
                    // A waiting debug request ages on every processor grant.
                    if (pick_dbg || !bus.dbg_req) begin
                        starve_count <= '0;
                    end else if (starve_count != STARVE_MAX) begin
                        starve_count <= starve_count + SW'(1);
                    end
                end
                ACCESS: begin
                    bus.mem_we <= 1'b0;
                    if (lat_cnt == LAST_CNT) begin
                        state <= ACK;
                        if (bus.grant_debug) begin
                            bus.dbg_ack <= 1'b1;
                            if (!req_we) bus.dbg_read_data <= bus.mem_read_data;
                        end else begin
                            bus.cpu_ack <= 1'b1;
                            if (!req_we) bus.cpu_read_data <= bus.mem_read_data;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + CW'(1);
                    end
                end
                ACK: begin
                    state           <= IDLE;
                    bus.cpu_ack     <= 1'b0;
                    bus.dbg_ack     <= 1'b0;
                    bus.busy        <= 1'b0;
                    bus.grant_debug <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter at read latencies 1 and 3.
// Each task drives one scenario and checks timing inline.
module tb_data_memory_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int DAW = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    data_memory_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEBUG_ADDRESS_WIDTH(DAW)) bus1 ();
    data_memory_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEBUG_ADDRESS_WIDTH(DAW)) bus3 ();

    data_memory_arbiter #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEBUG_ADDRESS_WIDTH(DAW),
        .READ_LATENCY(1), .STARVATION_LIMIT(4)
    ) u1 (.clock(clock), .reset(reset), .bus(bus1));

    data_memory_arbiter #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEBUG_ADDRESS_WIDTH(DAW),
        .READ_LATENCY(3), .STARVATION_LIMIT(4)
    ) u3 (.clock(clock), .reset(reset), .bus(bus3));

    logic [DW-1:0] ram1 [0:255];
    logic [DW-1:0] ram3 [0:255];
    logic          pl_we = 1'b0;
    logic [7:0]    pl_addr = 8'h0;
    logic [DW-1:0] pl_data = '0;
    logic [DW-1:0] p1;
    logic [DW-1:0] p2;

    always @(posedge clock) begin
        if (bus1.mem_we) ram1[bus1.mem_address[7:0]] <= bus1.mem_write_data;
        else if (pl_we) ram1[pl_addr] <= pl_data;
        if (bus3.mem_we) ram3[bus3.mem_address[7:0]] <= bus3.mem_write_data;
        else if (pl_we) ram3[pl_addr] <= pl_data;
    end

    assign bus1.mem_read_data = ram1[bus1.mem_address[7:0]];

    always @(posedge clock) begin
        p1 <= ram3[bus3.mem_address[7:0]];
        p2 <= p1;
    end
    assign bus3.mem_read_data = p2;

    typedef struct packed {
        logic          dbg;
        logic          we;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clock) begin
        if (bus1.cpu_ack || bus1.dbg_ack) begin
            checks++;
            if (bus1.cpu_ack && bus1.dbg_ack) begin
                errors++;
                $display("FAIL sb_both_acks cpu_ack=1 dbg_ack=1 required one ack");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ack cpu_ack=%0b dbg_ack=%0b required none",
                         bus1.cpu_ack, bus1.dbg_ack);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus1.dbg_ack !== e.dbg) begin
                    errors++;
                    $display("FAIL sb_side dbg_ack=%0b required %0b", bus1.dbg_ack, e.dbg);
                end else if (!e.we && e.dbg && bus1.dbg_read_data !== e.data) begin
                    errors++;
                    $display("FAIL sb_dbg_data got %h required %h", bus1.dbg_read_data, e.data);
                end else if (!e.we && !e.dbg && bus1.cpu_read_data !== e.data) begin
                    errors++;
                    $display("FAIL sb_cpu_data got %h required %h", bus1.cpu_read_data, e.data);
                end
            end
        end
    end

    task automatic idle_inputs();
        bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_address = '0; bus1.cpu_write_data = '0;
        bus1.dbg_req = 0; bus1.dbg_we = 0; bus1.dbg_address = '0; bus1.dbg_write_data = '0;
        bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_address = '0; bus3.cpu_write_data = '0;
        bus3.dbg_req = 0; bus3.dbg_we = 0; bus3.dbg_address = '0; bus3.dbg_write_data = '0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
        @(negedge clock);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clock);
        pl_we = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus1.busy, bus1.cpu_ack, bus1.dbg_ack, bus1.mem_we, bus1.grant_debug} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl busy/acks/we/grant=%b required 00000",
                     {bus1.busy, bus1.cpu_ack, bus1.dbg_ack, bus1.mem_we, bus1.grant_debug});
        end
        checks++;
        if (bus1.mem_address !== '0 || bus1.cpu_read_data !== '0 || bus1.dbg_read_data !== '0) begin
            errors++;
            $display("FAIL reset_data addr=%h cpu_rd=%h dbg_rd=%h required 0",
                     bus1.mem_address, bus1.cpu_read_data, bus1.dbg_read_data);
        end
        checks++;
        if (u1.starve_count !== '0) begin
            errors++;
            $display("FAIL reset_starve got %0d required 0", u1.starve_count);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_cpu_read();
        preload(8'h10, 32'hDEADBEEF);
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_address = 32'h10;
        sb.push_back(exp_t'{1'b0, 1'b0, 32'hDEADBEEF});
        @(negedge clock);
        checks++;
        if (bus1.mem_address !== 32'h10 || bus1.busy !== 1'b1 || bus1.cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL rd_cycle1 addr=%h busy=%b ack=%b required 10/1/0",
                     bus1.mem_address, bus1.busy, bus1.cpu_ack);
        end
        @(negedge clock);
        checks++;
        if (bus1.cpu_ack !== 1'b1 || bus1.cpu_read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_cycle2 ack=%b data=%h required 1/deadbeef",
                     bus1.cpu_ack, bus1.cpu_read_data);
        end
        bus1.cpu_req = 0;
        @(negedge clock);
        checks++;
        if (bus1.busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_cycle3_busy got %b required 0", bus1.busy);
        end
    endtask

    task automatic test_dbg_write();
        bus1.dbg_req = 1; bus1.dbg_we = 1; bus1.dbg_address = 6'h3F;
        bus1.dbg_write_data = 32'h12345678;
        sb.push_back(exp_t'{1'b1, 1'b1, 32'h0});
        @(negedge clock);
        checks++;
        if (bus1.mem_address !== 32'h3F || bus1.mem_we !== 1'b1 || bus1.grant_debug !== 1'b1
            || bus1.mem_write_data !== 32'h12345678) begin
            errors++;
            $display("FAIL wr_cycle1 addr=%h we=%b gnt=%b wd=%h required 3f/1/1/12345678",
                     bus1.mem_address, bus1.mem_we, bus1.grant_debug, bus1.mem_write_data);
        end
        @(negedge clock);
        checks++;
        if (bus1.mem_we !== 1'b0 || bus1.grant_debug !== 1'b1 || bus1.dbg_ack !== 1'b1) begin
            errors++;
            $display("FAIL wr_cycle2 we=%b gnt=%b ack=%b required 0/1/1",
                     bus1.mem_we, bus1.grant_debug, bus1.dbg_ack);
        end
        bus1.dbg_req = 0; bus1.dbg_we = 0;
        @(negedge clock);
        checks++;
        if (bus1.mem_we !== 1'b0 || bus1.busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_cycle3 we=%b busy=%b required 0/0", bus1.mem_we, bus1.busy);
        end
        bus1.dbg_req = 1;
        sb.push_back(exp_t'{1'b1, 1'b0, 32'h12345678});
        repeat (2) @(negedge clock);
        checks++;
        if (bus1.dbg_ack !== 1'b1 || bus1.dbg_read_data !== 32'h12345678) begin
            errors++;
            $display("FAIL wr_readback ack=%b data=%h required 1/12345678",
                     bus1.dbg_ack, bus1.dbg_read_data);
        end
        checks++;
        if (bus1.cpu_read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL other_side_hold cpu_rd=%h required deadbeef", bus1.cpu_read_data);
        end
        bus1.dbg_req = 0;
        @(negedge clock);
    endtask

    task automatic test_simultaneous();
        int cpu_cyc;
        int dbg_cyc;
        cpu_cyc = -1;
        dbg_cyc = -1;
        preload(8'h20, 32'hA5A50001);
        preload(8'h21, 32'h5A5A0002);
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_address = 32'h20;
        bus1.dbg_req = 1; bus1.dbg_we = 0; bus1.dbg_address = 6'h21;
        sb.push_back(exp_t'{1'b0, 1'b0, 32'hA5A50001});
        sb.push_back(exp_t'{1'b1, 1'b0, 32'h5A5A0002});
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (bus1.cpu_ack) begin cpu_cyc = c; bus1.cpu_req = 0; end
            if (bus1.dbg_ack) begin dbg_cyc = c; bus1.dbg_req = 0; end
        end
        checks++;
        if (cpu_cyc != 2 || dbg_cyc != 5) begin
            errors++;
            $display("FAIL simul_order cpu_ack@%0d dbg_ack@%0d required 2 and 5", cpu_cyc, dbg_cyc);
        end
    endtask

    task automatic test_contention();
        int cpu_acks;
        int dbg_cyc;
        int max_starve;
        int starve_after;
        cpu_acks = 0;
        dbg_cyc = -1;
        max_starve = 0;
        starve_after = -1;
        preload(8'h30, 32'h30303030);
        preload(8'h31, 32'h31313131);
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_address = 32'h30;
        bus1.dbg_req = 1; bus1.dbg_we = 0; bus1.dbg_address = 6'h31;
        for (int i = 0; i < 4; i++) sb.push_back(exp_t'{1'b0, 1'b0, 32'h30303030});
        sb.push_back(exp_t'{1'b1, 1'b0, 32'h31313131});
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (int'(u1.starve_count) > max_starve) max_starve = int'(u1.starve_count);
            if (bus1.grant_debug && starve_after < 0) starve_after = int'(u1.starve_count);
            if (bus1.cpu_ack && dbg_cyc < 0) cpu_acks++;
            if (bus1.dbg_ack) begin dbg_cyc = c; bus1.dbg_req = 0; bus1.cpu_req = 0; end
        end
        checks++;
        if (cpu_acks != 4 || dbg_cyc != 14) begin
            errors++;
            $display("FAIL starve_grants cpu=%0d dbg_ack@%0d required 4 and 14", cpu_acks, dbg_cyc);
        end
        checks++;
        if (max_starve != 4) begin
            errors++;
            $display("FAIL starve_peak got %0d required 4", max_starve);
        end
        checks++;
        if (starve_after != 0) begin
            errors++;
            $display("FAIL starve_clear got %0d required 0", starve_after);
        end
    endtask

    task automatic test_reset_mid_access();
        int ack_cyc;
        ack_cyc = -1;
        preload(8'h40, 32'h11111111);
        bus1.cpu_req = 1; bus1.cpu_we = 1; bus1.cpu_address = 32'h40;
        bus1.cpu_write_data = 32'hCAFEF00D;
        @(posedge clock);
        #2;
        checks++;
        if (bus1.mem_we !== 1'b1 || bus1.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre we=%b busy=%b required 1/1", bus1.mem_we, bus1.busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus1.mem_we, bus1.busy, bus1.cpu_ack, bus1.dbg_ack, bus1.grant_debug} !== 5'b0) begin
            errors++;
            $display("FAIL mid_async we/busy/acks/gnt=%b required 00000",
                     {bus1.mem_we, bus1.busy, bus1.cpu_ack, bus1.dbg_ack, bus1.grant_debug});
        end
        bus1.cpu_req = 0; bus1.cpu_we = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        bus1.cpu_req = 1;
        sb.push_back(exp_t'{1'b0, 1'b0, 32'h11111111});
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            if (bus1.cpu_ack) begin ack_cyc = c; bus1.cpu_req = 0; end
        end
        checks++;
        if (ack_cyc != 2) begin
            errors++;
            $display("FAIL mid_recover ack@%0d required 2", ack_cyc);
        end
    endtask

    task automatic test_latency3();
        int ack_a;
        int ack_b;
        ack_a = -1;
        ack_b = -1;
        preload(8'h50, 32'h0BADF00D);
        bus3.cpu_req = 1; bus3.cpu_we = 0; bus3.cpu_address = 32'h50;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (c <= 3) begin
                checks++;
                if (bus3.mem_address !== 32'h50 || bus3.cpu_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL lat3_hold c%0d addr=%h ack=%b required 50/0",
                             c, bus3.mem_address, bus3.cpu_ack);
                end
            end
            if (c == 5) begin
                checks++;
                if (bus3.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL lat3_idle busy=%b required 0", bus3.busy);
                end
            end
            if (bus3.cpu_ack) begin
                checks++;
                if (bus3.cpu_read_data !== 32'h0BADF00D) begin
                    errors++;
                    $display("FAIL lat3_data got %h required 0badf00d", bus3.cpu_read_data);
                end
                if (ack_a < 0) ack_a = c;
                else begin ack_b = c; bus3.cpu_req = 0; end
            end
        end
        checks++;
        if (ack_a != 4 || ack_b != 9) begin
            errors++;
            $display("FAIL lat3_acks first@%0d second@%0d required 4 and 9", ack_a, ack_b);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_dbg_write();
        test_simultaneous();
        test_contention();
        test_reset_mid_access();
        test_latency3();
        repeat (3) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover pending=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
